// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// Holds one operation in flight, captures its result ALU_LAT edges after issue and holds it until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_op,
  input  logic [47:0] req_src,
  input  logic [5:0]  req_flags,
  output logic [3:0]  alu_op_code,
  output logic [7:0]  alu_src1,
  output logic [7:0]  alu_src2,
  output logic [7:0]  alu_src3,
  output logic        alu_srcCy,
  output logic        alu_srcAc,
  output logic        alu_bit_in,
  input  logic [7:0]  alu_des1,
  input  logic [7:0]  alu_des2,
  input  logic [7:0]  alu_des_acc,
  input  logic        alu_desCy,
  input  logic        alu_desAc,
  input  logic        alu_desOv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_des1,
  output logic [7:0]  rsp_des2,
  output logic [7:0]  rsp_acc,
  output logic [2:0]  rsp_flags,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [23:0]        src_q, src_d;
  logic [2:0]         flags_q, flags_d;
  logic               rsp_id_q, rsp_id_d;
  logic [7:0]         des1_q, des1_d;
  logic [7:0]         des2_q, des2_d;
  logic [7:0]         acc_q, acc_d;
  logic [2:0]         rflags_q, rflags_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic [1:0]         grant_c;
  logic               accept_c;
  logic               sel_c;

  // Grant only in IDLE and out of reset; on a tie the requester not served last wins.
  always_comb begin
    grant_c = 2'b00;
    if (rst && (state_q == IDLE)) begin
      unique case (req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = rr_q ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

  assign accept_c  = |(req_valid & grant_c);
  assign sel_c     = grant_c[1];
  assign req_ready = grant_c;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    src_d    = src_q;
    flags_d  = flags_q;
    rsp_id_d = rsp_id_q;
    des1_d   = des1_q;
    des2_d   = des2_q;
    acc_d    = acc_q;
    rflags_d = rflags_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          op_d     = sel_c ? req_op[7:4]      : req_op[3:0];
          src_d    = sel_c ? req_src[47:24]   : req_src[23:0];
          flags_d  = sel_c ? req_flags[5:3]   : req_flags[2:0];
          rsp_id_d = sel_c;
          rr_d     = sel_c;
          cnt_d    = CNT_W'(ALU_LAT);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          des1_d   = alu_des1;
          des2_d   = alu_des2;
          acc_d    = alu_des_acc;
          rflags_d = {alu_desOv, alu_desAc, alu_desCy};
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b1;
      cnt_q       <= '0;
      op_q        <= '0;
      src_q       <= '0;
      flags_q     <= '0;
      rsp_id_q    <= 1'b0;
      des1_q      <= '0;
      des2_q      <= '0;
      acc_q       <= '0;
      rflags_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      src_q       <= src_d;
      flags_q     <= flags_d;
      rsp_id_q    <= rsp_id_d;
      des1_q      <= des1_d;
      des2_q      <= des2_d;
      acc_q       <= acc_d;
      rflags_q    <= rflags_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_op_code = op_q;
  assign alu_src1    = src_q[7:0];
  assign alu_src2    = src_q[15:8];
  assign alu_src3    = src_q[23:16];
  assign alu_srcCy   = flags_q[0];
  assign alu_srcAc   = flags_q[1];
  assign alu_bit_in  = flags_q[2];
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_des1    = des1_q;
  assign rsp_des2    = des2_q;
  assign rsp_acc     = acc_q;
  assign rsp_flags   = rflags_q;
  assign busy        = busy_q;

endmodule
